// File: rtl/pu_weight_pkg.sv
// Shared types and defaults for the PU repetition weight-buffer fetch path.
package pu_weight_pkg;

  localparam int WEIGHT_SRAM_LEN = 32;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ADDR_W      = 16;

  typedef logic [WEIGHT_SRAM_LEN-1:0] weight_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_PAD,
    ST_FLUSH
  } fetch_state_t;

endpackage

// File: rtl/pu_weight_fetch_fifo.sv
// Small synchronous prefetch FIFO with synchronous clear and a head-of-queue output.
module pu_weight_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = 1;
  localparam logic [PTR_W:0]   CNT_ONE    = 1;
  localparam logic [PTR_W:0]   FULL_COUNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push & ((count != FULL_COUNT) | do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pu_weight_word_fetcher.sv
// Prefetches the weight stream from SRAM into a FIFO and serves the weight buffer's word handshake.
// Define WEIGHT_FETCH_CHECK_EN to enable the sticky word-index check on addr_err.
module pu_weight_word_fetcher
  import pu_weight_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       finish,
  input  logic                       enable,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [31:0]                num_words,
  input  logic                       word_read,
  input  logic [31:0]                word_counter,
  output logic                       word_ready,
  output logic [WEIGHT_SRAM_LEN-1:0] SRAM_out,
  output logic                       sram_req,
  output logic [ADDR_W-1:0]          sram_addr,
  input  logic                       sram_gnt,
  input  logic                       sram_rvalid,
  input  logic [WEIGHT_SRAM_LEN-1:0] sram_rdata,
  output logic                       busy,
  output logic                       addr_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       num_q;
  logic [31:0]       issued;
  logic [31:0]       inflight;
  logic [31:0]       delivered;
  logic [31:0]       issued_next;
  logic [31:0]       inflight_next;
  logic [31:0]       delivered_next;
  logic [31:0]       occupancy_next;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_clear;
  logic              fifo_push;
  logic              fifo_pop;
  weight_word_t      fifo_head;
  logic              grant;
  logic              in_stream;
  logic              rvalid_ret;

  assign in_stream  = (state == ST_RUN) || (state == ST_DRAIN);
  assign grant      = sram_req & sram_gnt;
  assign fifo_push  = sram_rvalid & in_stream;
  assign fifo_pop   = word_ready & enable & in_stream;
  assign fifo_clear = ((state == ST_IDLE) && start) || ((state != ST_IDLE) && finish);
  assign busy       = (state != ST_IDLE);
  // Returns that arrive in IDLE belong to a stream cut off by reset and are ignored.
  assign rvalid_ret = sram_rvalid && (state != ST_IDLE) && (inflight != 32'd0);

  assign issued_next    = issued + {31'd0, grant};
  assign inflight_next  = inflight + {31'd0, grant} - {31'd0, rvalid_ret};
  assign delivered_next = delivered + {31'd0, fifo_pop};
  assign occupancy_next = 32'(fifo_count) + {31'd0, fifo_push} - {31'd0, fifo_pop} + inflight_next;

  always_comb begin
    word_ready = 1'b0;
    SRAM_out   = '0;
    case (state)
      ST_RUN, ST_DRAIN: begin
        word_ready = word_read & ~fifo_empty;
        SRAM_out   = (word_read & ~fifo_empty) ? fifo_head : '0;
      end
      ST_PAD:  word_ready = word_read;
      default: ;
    endcase
  end

  pu_weight_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WEIGHT_SRAM_LEN)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (sram_rdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Requests are decided from next-cycle occupancy so sram_req can be registered yet never overrun the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      issued    <= '0;
      inflight  <= '0;
      delivered <= '0;
      sram_req  <= 1'b0;
      sram_addr <= '0;
    end else if (finish && (state != ST_IDLE)) begin
      state    <= ST_FLUSH;
      sram_req <= 1'b0;
      inflight <= inflight_next;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            num_q     <= num_words;
            issued    <= '0;
            inflight  <= '0;
            delivered <= '0;
            sram_addr <= base_addr;
            sram_req  <= (num_words != 32'd0);
            state     <= (num_words == 32'd0) ? ST_PAD : ST_RUN;
          end
        end
        ST_RUN: begin
          issued    <= issued_next;
          inflight  <= inflight_next;
          delivered <= delivered_next;
          sram_addr <= base_q + issued_next[ADDR_W-1:0];
          if (issued_next == num_q) begin
            sram_req <= 1'b0;
            state    <= ST_DRAIN;
          end else begin
            sram_req <= (occupancy_next < 32'(FIFO_DEPTH));
          end
        end
        ST_DRAIN: begin
          inflight  <= inflight_next;
          delivered <= delivered_next;
          if (delivered_next == num_q) state <= ST_PAD;
        end
        ST_PAD: ;
        ST_FLUSH: begin
          inflight <= inflight_next;
          if (inflight_next == 32'd0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WEIGHT_FETCH_CHECK_EN
  // Only real stream words are checked; PAD-phase reads never pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_err <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      addr_err <= 1'b0;
    end else if (fifo_pop && (word_counter != delivered)) begin
      addr_err <= 1'b1;
    end
  end
`else
  logic unused_word_counter;
  assign unused_word_counter = ^word_counter;
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_pu_weight_word_fetcher.sv
// Directed self-checking bench for pu_weight_word_fetcher with a simple in-order SRAM model.
module tb_pu_weight_word_fetcher;
  import pu_weight_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        finish;
  logic        enable;
  logic [15:0] base_addr;
  logic [31:0] num_words;
  logic        word_read;
  logic [31:0] word_counter;
  logic        word_ready;
  logic [31:0] SRAM_out;
  logic        sram_req;
  logic [15:0] sram_addr;
  logic        sram_gnt;
  logic        sram_rvalid;
  logic [31:0] sram_rdata;
  logic        busy;
  logic        addr_err;

  int          compared = 0;
  int          mismatched = 0;
  int          lat = 1;
  int          rv_seen = 0;
  int          rv_base;
  logic        pend_v [8];
  logic [15:0] pend_a [8];
  logic [15:0] req_log [$];
  logic [31:0] got [$];

`ifdef WEIGHT_FETCH_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clock = ~clock;

  pu_weight_word_fetcher #(
    .FIFO_DEPTH (4),
    .ADDR_W     (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .finish       (finish),
    .enable       (enable),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .word_read    (word_read),
    .word_counter (word_counter),
    .word_ready   (word_ready),
    .SRAM_out     (SRAM_out),
    .sram_req     (sram_req),
    .sram_addr    (sram_addr),
    .sram_gnt     (sram_gnt),
    .sram_rvalid  (sram_rvalid),
    .sram_rdata   (sram_rdata),
    .busy         (busy),
    .addr_err     (addr_err)
  );

  function automatic logic [31:0] word_of(input logic [15:0] a);
    return {16'hA000, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: log this cycle's grant, then advance the SRAM return pipeline.
  task automatic tick();
    logic        g;
    logic [15:0] a;
    g = sram_req & sram_gnt;
    a = sram_addr;
    if (g) req_log.push_back(a);
    @(posedge clock);
    #1;
    for (int i = 7; i > 0; i--) begin
      pend_v[i] = pend_v[i-1];
      pend_a[i] = pend_a[i-1];
    end
    pend_v[0]   = g;
    pend_a[0]   = a;
    sram_rvalid = pend_v[lat-1];
    sram_rdata  = pend_v[lat-1] ? word_of(pend_a[lat-1]) : 32'h0;
    if (sram_rvalid) rv_seen++;
  endtask

  task automatic applyStimulus(input logic [15:0] base, input logic [31:0] num);
    for (int i = 0; i < 8; i++) pend_v[i] = 1'b0;
    req_log.delete();
    base_addr = base;
    num_words = num;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic collect(input int n, input int max_cycles);
    got.delete();
    word_read = 1'b1;
    enable    = 1'b1;
    for (int c = 0; c < max_cycles && got.size() < n; c++) begin
      word_counter = got.size();
      #1;
      if (word_ready) got.push_back(SRAM_out);
      tick();
    end
    word_read = 1'b0;
    checkOutput("collect_count", got.size(), n);
  endtask

  task automatic endStream(input string tag);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    checkOutput(tag, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; finish = 1'b0; enable = 1'b1;
    base_addr = '0; num_words = '0; word_read = 1'b1; word_counter = '0;
    sram_gnt = 1'b1; sram_rvalid = 1'b0; sram_rdata = '0;
    for (int i = 0; i < 8; i++) begin pend_v[i] = 1'b0; pend_a[i] = '0; end

    #2;
    checkOutput("rst_word_ready", word_ready, 1'b0);
    checkOutput("rst_sram_out", SRAM_out, 32'h0);
    checkOutput("rst_sram_req", sram_req, 1'b0);
    checkOutput("rst_sram_addr", sram_addr, 16'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_addr_err", addr_err, 1'b0);
    tick(); tick();
    reset = 1'b1;
    word_read = 1'b0;
    tick();

    // Basic stream, single-cycle SRAM, continuous reads, padding after the end.
    lat = 1;
    applyStimulus(16'h0010, 32'd3);
    checkOutput("t1_req_after_start", sram_req, 1'b1);
    checkOutput("t1_addr_after_start", sram_addr, 16'h0010);
    collect(4, 30);
    checkOutput("t1_word0", got[0], 32'hA000_0010);
    checkOutput("t1_word1", got[1], 32'hA000_0011);
    checkOutput("t1_word2", got[2], 32'hA000_0012);
    checkOutput("t1_pad_word", got[3], 32'h0);
    checkOutput("t1_req_count", req_log.size(), 3);
    checkOutput("t1_req_addr0", req_log[0], 16'h0010);
    checkOutput("t1_req_addr1", req_log[1], 16'h0011);
    checkOutput("t1_req_addr2", req_log[2], 16'h0012);
    checkOutput("t1_addr_err", addr_err, 1'b0);
    checkOutput("t1_busy_pad", busy, 1'b1);
    endStream("t1_idle");

    // Long latency, no consumer: prefetch stops at FIFO depth until the first pop.
    lat = 5;
    applyStimulus(16'h0100, 32'd8);
    repeat (12) tick();
    checkOutput("t2_req_count", req_log.size(), 4);
    checkOutput("t2_req_stalled", sram_req, 1'b0);
    word_counter = 32'd0;
    word_read = 1'b1;
    #1;
    checkOutput("t2_first_ready", word_ready, 1'b1);
    checkOutput("t2_first_word", SRAM_out, 32'hA000_0100);
    tick();
    word_read = 1'b0;
    #1;
    checkOutput("t2_req_resume", sram_req, 1'b1);
    checkOutput("t2_addr_resume", sram_addr, 16'h0104);

    // Consumer stall: head and word_ready held while enable is low.
    word_read = 1'b1;
    enable = 1'b0;
    word_counter = 32'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t3_stall_ready", word_ready, 1'b1);
      checkOutput("t3_stall_word", SRAM_out, 32'hA000_0101);
      tick();
    end
    enable = 1'b1;
    #1;
    checkOutput("t3_release_word", SRAM_out, 32'hA000_0101);
    tick();
    #1;
    checkOutput("t3_next_word", SRAM_out, 32'hA000_0102);
    checkOutput("t3_addr_err", addr_err, 1'b0);
    word_read = 1'b0;
    endStream("t3_idle");

    // Finish with two reads in flight: FLUSH holds busy until both return.
    lat = 5;
    applyStimulus(16'h0200, 32'd4);
    tick(); tick();
    sram_gnt = 1'b0;
    finish = 1'b1;
    word_read = 1'b1;
    tick();
    finish = 1'b0;
    sram_gnt = 1'b1;
    rv_base = rv_seen;
    #1;
    checkOutput("t4_flush_busy", busy, 1'b1);
    checkOutput("t4_flush_ready", word_ready, 1'b0);
    checkOutput("t4_flush_req", sram_req, 1'b0);
    for (int i = 0; i < 20 && busy; i++) tick();
    checkOutput("t4_idle", busy, 1'b0);
    checkOutput("t4_returns_seen", rv_seen - rv_base, 2);
    word_read = 1'b0;
    lat = 1;
    applyStimulus(16'h0300, 32'd2);
    collect(2, 20);
    checkOutput("t4_new_word0", got[0], 32'hA000_0300);
    checkOutput("t4_new_word1", got[1], 32'hA000_0301);
    endStream("t4_idle_b");

    // Wrong word index on the first pop.
    lat = 1;
    applyStimulus(16'h0400, 32'd2);
    word_read = 1'b1;
    word_counter = 32'd1;
    #1;
    for (int i = 0; i < 20 && !word_ready; i++) begin tick(); #1; end
    checkOutput("t5_first_ready", word_ready, 1'b1);
    tick();
    checkOutput("t5_addr_err_set", addr_err, EXP_ERR);
    #1;
    for (int i = 0; i < 20 && !word_ready; i++) begin tick(); #1; end
    tick();
    repeat (3) tick();
    checkOutput("t5_addr_err_sticky", addr_err, EXP_ERR);
    word_read = 1'b0;
    endStream("t5_idle");
    checkOutput("t5_addr_err_held", addr_err, EXP_ERR);

    // Empty stream goes straight to padding; start clears the error flag.
    applyStimulus(16'h0050, 32'd0);
    checkOutput("t6_addr_err_cleared", addr_err, 1'b0);
    word_read = 1'b1;
    #1;
    checkOutput("t6_pad_ready", word_ready, 1'b1);
    checkOutput("t6_pad_word", SRAM_out, 32'h0);
    checkOutput("t6_pad_busy", busy, 1'b1);
    repeat (3) tick();
    checkOutput("t6_no_requests", req_log.size(), 0);
    checkOutput("t6_req_low", sram_req, 1'b0);
    word_read = 1'b0;
    endStream("t6_idle");

    // Address wraps past the top of the SRAM.
    applyStimulus(16'hFFFF, 32'd2);
    repeat (6) tick();
    checkOutput("t6_wrap_count", req_log.size(), 2);
    checkOutput("t6_wrap_addr0", req_log[0], 16'hFFFF);
    checkOutput("t6_wrap_addr1", req_log[1], 16'h0000);
    endStream("t6_idle_b");

    // Reset mid-stream; late returns are dropped in IDLE.
    lat = 5;
    applyStimulus(16'h0600, 32'd4);
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("t7_rst_busy", busy, 1'b0);
    checkOutput("t7_rst_req", sram_req, 1'b0);
    checkOutput("t7_rst_addr", sram_addr, 16'h0);
    tick();
    reset = 1'b1;
    repeat (8) tick();
    word_read = 1'b1;
    #1;
    checkOutput("t7_idle_busy", busy, 1'b0);
    checkOutput("t7_idle_ready", word_ready, 1'b0);
    word_read = 1'b0;
    lat = 1;
    applyStimulus(16'h0700, 32'd1);
    collect(2, 20);
    checkOutput("t7_word0", got[0], 32'hA000_0700);
    checkOutput("t7_pad_word", got[1], 32'h0);
    endStream("t7_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
